// File: rtl/sevenseg_decoder.sv
// Recovers per-digit symbols from a multiplexed active-low seven-segment bus.
// Define SEVENSEG_DEC_HEX_EN to decode the A..F glyphs as hex digits 10..15.
module sevenseg_decoder #(
    parameter int NUM_DIGITS    = 6,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [7:0]                seg_in,
    input  logic [NUM_DIGITS-1:0]     dig_sel_n,
    input  logic                      out_ready,
    input  logic                      clr_err,
    output logic                      out_valid,
    output logic [2:0]                out_digit,
    output logic [1:0]                out_kind,
    output logic [3:0]                out_value,
    output logic                      out_dp,
    output logic [4*NUM_DIGITS-1:0]   bank_value,
    output logic [2*NUM_DIGITS-1:0]   bank_kind,
    output logic                      err_ovf
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam int SW = NUM_DIGITS + 8;

    typedef enum logic [1:0] {
        K_DIGIT   = 2'd0,
        K_BLANK   = 2'd1,
        K_MINUS   = 2'd2,
        K_INVALID = 2'd3
    } kind_t;

    logic [SW-1:0]         samp;
    logic [CW-1:0]         cnt;
    logic                  done;
    logic [3:0]            val_q  [NUM_DIGITS];
    logic [1:0]            kind_q [NUM_DIGITS];
    logic                  dp_q   [NUM_DIGITS];

    logic                  changed;
    logic [NUM_DIGITS-1:0] sel;
    logic                  one_hot;
    logic [2:0]            idx;
    logic                  accept;
    logic [1:0]            dk;
    logic [3:0]            dv;
    logic                  ddp;
    logic [6:0]            prev;
    logic                  ev;

    function automatic logic [5:0] decode(input logic [6:0] p);
        logic [5:0] r;
        r = {K_INVALID, 4'd0};
        case (p)
            7'h40: r = {K_DIGIT, 4'd0};
            7'h79: r = {K_DIGIT, 4'd1};
            7'h24: r = {K_DIGIT, 4'd2};
            7'h30: r = {K_DIGIT, 4'd3};
            7'h19: r = {K_DIGIT, 4'd4};
            7'h12: r = {K_DIGIT, 4'd5};
            7'h02: r = {K_DIGIT, 4'd6};
            7'h78: r = {K_DIGIT, 4'd7};
            7'h00: r = {K_DIGIT, 4'd8};
            7'h10: r = {K_DIGIT, 4'd9};
            7'h7F: r = {K_BLANK, 4'd0};
            7'h3F: r = {K_MINUS, 4'd0};
`ifdef SEVENSEG_DEC_HEX_EN
            7'h08: r = {K_DIGIT, 4'd10};
            7'h03: r = {K_DIGIT, 4'd11};
            7'h46: r = {K_DIGIT, 4'd12};
            7'h21: r = {K_DIGIT, 4'd13};
            7'h06: r = {K_DIGIT, 4'd14};
            7'h0E: r = {K_DIGIT, 4'd15};
`else
            7'h08, 7'h03, 7'h46,
            7'h21, 7'h06, 7'h0E: r = {K_INVALID, 4'd0};
`endif
            default: r = {K_INVALID, 4'd0};
        endcase
        return r;
    endfunction

    always_comb begin
        changed = {dig_sel_n, seg_in} != samp;
        sel     = ~samp[SW-1:8];
        one_hot = (sel != '0) &&
                  ((sel & (sel - NUM_DIGITS'(1))) == '0);
        idx     = '0;
        prev    = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (sel[i]) begin
                idx  = 3'(i);
                prev = {kind_q[i], val_q[i], dp_q[i]};
            end
        end
        accept    = (cnt == CW'(STABLE_CYCLES)) && !done && one_hot;
        {dk, dv}  = decode(samp[6:0]);
        ddp       = ~samp[7];
        ev        = accept && ({dk, dv, ddp} != prev);
    end

    // Counter restarts at 1 on every sample change; done blocks re-firing.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            samp <= '1;
            cnt  <= '0;
            done <= 1'b0;
        end else begin
            samp <= {dig_sel_n, seg_in};
            if (changed) begin
                cnt  <= CW'(1);
                done <= 1'b0;
            end else begin
                if (cnt != CW'(STABLE_CYCLES))
                    cnt <= cnt + CW'(1);
                done <= (cnt == CW'(STABLE_CYCLES));
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                val_q[i]  <= 4'd0;
                kind_q[i] <= K_BLANK;
                dp_q[i]   <= 1'b0;
            end
        end else begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (accept && sel[i]) begin
                    val_q[i]  <= dv;
                    kind_q[i] <= dk;
                    dp_q[i]   <= ddp;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_digit <= 3'd0;
            out_kind  <= 2'd0;
            out_value <= 4'd0;
            out_dp    <= 1'b0;
            err_ovf   <= 1'b0;
        end else begin
            if (out_valid && !out_ready) begin
                if (ev)
                    err_ovf <= 1'b1;
                else if (clr_err)
                    err_ovf <= 1'b0;
            end else begin
                out_valid <= ev;
                if (ev) begin
                    out_digit <= idx;
                    out_kind  <= dk;
                    out_value <= dv;
                    out_dp    <= ddp;
                end
                if (clr_err)
                    err_ovf <= 1'b0;
            end
        end
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_bank
        assign bank_value[4*g +: 4] = val_q[g];
        assign bank_kind[2*g +: 2]  = kind_q[g];
    end

endmodule

// File: tb/tb_sevenseg_decoder.sv
// Self-checking bench for sevenseg_decoder: vector table plus scoreboard.
// Honours SEVENSEG_DEC_HEX_EN the same way as the design.
module tb_sevenseg_decoder;

`ifdef SEVENSEG_DEC_HEX_EN
    localparam bit HEX = 1'b1;
`else
    localparam bit HEX = 1'b0;
`endif

    logic        clk;
    logic        reset_n;
    logic [7:0]  seg_in;
    logic [5:0]  dig_sel_n;
    logic        out_ready;
    logic        clr_err;
    logic        out_valid;
    logic [2:0]  out_digit;
    logic [1:0]  out_kind;
    logic [3:0]  out_value;
    logic        out_dp;
    logic [23:0] bank_value;
    logic [11:0] bank_kind;
    logic        err_ovf;

    int checks = 0;
    int fails  = 0;

    logic [9:0] exp_q [$];

    typedef struct {
        logic [5:0] sel;
        logic [7:0] seg;
        bit         ev;
        logic [2:0] dig;
        logic [1:0] kind;
        logic [3:0] val;
        logic       dp;
    } vec_t;

    vec_t tbl [16];

    sevenseg_decoder #(
        .NUM_DIGITS(6),
        .STABLE_CYCLES(4)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .seg_in(seg_in),
        .dig_sel_n(dig_sel_n),
        .out_ready(out_ready),
        .clr_err(clr_err),
        .out_valid(out_valid),
        .out_digit(out_digit),
        .out_kind(out_kind),
        .out_value(out_value),
        .out_dp(out_dp),
        .bank_value(bank_value),
        .bank_kind(bank_kind),
        .err_ovf(err_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic set_v(input int i, input logic [5:0] sel,
                         input logic [7:0] seg, input bit ev,
                         input logic [2:0] dig, input logic [1:0] kind,
                         input logic [3:0] val, input logic dp);
        tbl[i] = '{sel, seg, ev, dig, kind, val, dp};
    endtask

    // Called at posedge+1; leaves at posedge+1 after n edges.
    task automatic apply(input logic [5:0] sel, input logic [7:0] seg,
                         input int n);
        dig_sel_n = sel;
        seg_in    = seg;
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_event: got %h expected none",
                         {out_digit, out_kind, out_value, out_dp});
            end else begin
                chk("event", {22'd0, out_digit, out_kind, out_value, out_dp},
                    {22'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        set_v(0,  6'b111110, 8'hC0, 1, 3'd0, 2'd0, 4'd0, 1'b0);
        set_v(1,  6'b111101, 8'hF9, 1, 3'd1, 2'd0, 4'd1, 1'b0);
        set_v(2,  6'b111011, 8'hA4, 1, 3'd2, 2'd0, 4'd2, 1'b0);
        set_v(3,  6'b110111, 8'hB0, 1, 3'd3, 2'd0, 4'd3, 1'b0);
        set_v(4,  6'b101111, 8'h99, 1, 3'd4, 2'd0, 4'd4, 1'b0);
        set_v(5,  6'b011111, 8'h92, 1, 3'd5, 2'd0, 4'd5, 1'b0);
        set_v(6,  6'b111011, 8'h88, 1, 3'd2, HEX ? 2'd0 : 2'd3,
              HEX ? 4'd10 : 4'd0, 1'b0);
        set_v(7,  6'b111011, 8'hBF, 1, 3'd2, 2'd2, 4'd0, 1'b0);
        set_v(8,  6'b111011, 8'h2A, 1, 3'd2, 2'd3, 4'd0, 1'b1);
        set_v(9,  6'b111011, 8'hC6, 1, 3'd2, HEX ? 2'd0 : 2'd3,
              HEX ? 4'd12 : 4'd0, 1'b0);
        set_v(10, 6'b111011, 8'hFF, 1, 3'd2, 2'd1, 4'd0, 1'b0);
        set_v(11, 6'b111011, 8'h7F, 1, 3'd2, 2'd1, 4'd0, 1'b1);
        set_v(12, 6'b110111, 8'h40, 1, 3'd3, 2'd0, 4'd0, 1'b1);
        set_v(13, 6'b111111, 8'h80, 0, 3'd0, 2'd0, 4'd0, 1'b0);
        set_v(14, 6'b110110, 8'h80, 0, 3'd0, 2'd0, 4'd0, 1'b0);
        set_v(15, 6'b011111, 8'h92, 0, 3'd0, 2'd0, 4'd0, 1'b0);

        reset_n   = 1'b0;
        dig_sel_n = 6'b111111;
        seg_in    = 8'hFF;
        out_ready = 1'b0;
        clr_err   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_payload", {out_digit, out_kind, out_value, out_dp}, 0);
        reset_n = 1'b1;

        // Dark display
        apply(6'b111111, 8'hFF, 20);
        chk("dark_valid", out_valid, 0);
        chk("dark_kind", bank_kind, 12'h555);
        chk("dark_value", bank_value, 0);
        chk("dark_err", err_ovf, 0);

        // Latency: held from edge k, valid after edge k+4
        dig_sel_n = 6'b111110;
        seg_in    = 8'hA4;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("lat_early", out_valid, 0);
        @(posedge clk);
        @(negedge clk);
        chk("lat_valid", out_valid, 1);
        chk("lat_payload", {out_digit, out_kind, out_value, out_dp},
            {3'd0, 2'd0, 4'd2, 1'b0});
        exp_q.push_back({3'd0, 2'd0, 4'd2, 1'b0});
        out_ready = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        chk("lat_no_second", out_valid, 0);

        // Glitch on digit 1
        apply(6'b111101, 8'h99, 3);
        exp_q.push_back({3'd1, 2'd0, 4'd5, 1'b0});
        apply(6'b111101, 8'h92, 10);

        // Scan, three passes; events only on the first
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 6; i++) begin
                if (p == 0 && tbl[i].ev)
                    exp_q.push_back({tbl[i].dig, tbl[i].kind,
                                     tbl[i].val, tbl[i].dp});
                apply(tbl[i].sel, tbl[i].seg, 8);
            end
        end
        chk("scan_value", bank_value, 24'h543210);
        chk("scan_kind", bank_kind, 12'h000);
        chk("scan_drained", exp_q.size(), 0);

        // Decode corners
        for (int i = 6; i < 16; i++) begin
            if (tbl[i].ev)
                exp_q.push_back({tbl[i].dig, tbl[i].kind,
                                 tbl[i].val, tbl[i].dp});
            apply(tbl[i].sel, tbl[i].seg, 8);
        end
        chk("dec_value", bank_value, 24'h540010);
        chk("dec_kind", bank_kind, 12'h010);
        chk("dec_drained", exp_q.size(), 0);

        // Overflow: first held, second dropped
        out_ready = 1'b0;
        apply(6'b111110, 8'hF9, 8);
        apply(6'b111101, 8'hA4, 8);
        chk("ovf_valid", out_valid, 1);
        chk("ovf_payload", {out_digit, out_kind, out_value, out_dp},
            {3'd0, 2'd0, 4'd1, 1'b0});
        chk("ovf_err", err_ovf, 1);
        chk("ovf_bank1", bank_value[7:4], 4'd2);
        exp_q.push_back({3'd0, 2'd0, 4'd1, 1'b0});
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("ovf_err_sticky", err_ovf, 1);
        clr_err = 1'b1;
        @(posedge clk);
        #1;
        clr_err = 1'b0;
        chk("clr_err", err_ovf, 0);

        // Reset mid-event
        out_ready = 1'b0;
        apply(6'b101111, 8'hF9, 8);
        chk("mid_valid", out_valid, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_kind", bank_kind, 12'h555);
        chk("mid_rst_value", bank_value, 0);
        chk("mid_rst_err", err_ovf, 0);
        dig_sel_n = 6'b111111;
        seg_in    = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        reset_n   = 1'b1;
        out_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("end_valid", out_valid, 0);
        chk("end_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
